// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared state encoding and region decode for the fx68k bus responder
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    BERR
  } bus_state_t;

  localparam logic [1:0] REG_ROM  = 2'd0;
  localparam logic [1:0] REG_VRAM = 2'd1;
  localparam logic [1:0] REG_RAM  = 2'd2;

  // eab carries byte-address bits 23:1, so byte-address bits 17:15 live at eab[16:14]
  function automatic logic [1:0] decode_region(input logic [22:0] eab);
    logic [2:0] blk;
    blk = eab[16:14];
    if (blk < 3'd2) begin
      return REG_ROM;
    end else if (blk == 3'd2) begin
      return REG_VRAM;
    end else begin
      return REG_RAM;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/m68k_bus_responder.sv
// rtl/m68k_bus_responder.sv - fx68k bus slave: decodes CPU cycles into memory requests, drives DTACKn/BERRn
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter int C_WAIT         = 0,
  parameter int C_TIMEOUT_BITS = 8,
  parameter bit C_ROM_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [22:0] addr,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_sel,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [3:0] WAIT_INIT = 4'(C_WAIT);
  // Timeout fires on the edge the watchdog reaches all-ones
  localparam logic [C_TIMEOUT_BITS-1:0] WD_LAST = {{(C_TIMEOUT_BITS-1){1'b1}}, 1'b0};

  bus_state_t state, state_d;

  logic        rw_q, rw_d;
  logic        abort_q, abort_d;
  logic [3:0]  wait_cnt, wait_d;
  logic [15:0] din_d;
  logic        dtack_d, berr_d, req_d, we_d;
  logic [1:0]  sel_d, be_d;
  logic [22:0] addr_d;
  logic [15:0] wdata_d;
  logic        strobe;
  logic        aborted;
  logic [1:0]  region;
  logic [C_TIMEOUT_BITS-1:0] wd_count;

  sat_counter #(
    .W (C_TIMEOUT_BITS)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .en    (state == REQ),
    .count (wd_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rw_q      <= 1'b1;
      abort_q   <= 1'b0;
      wait_cnt  <= '0;
      cpu_din   <= '0;
      dtack_n   <= 1'b1;
      berr_n    <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= REG_ROM;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      rw_q      <= rw_d;
      abort_q   <= abort_d;
      wait_cnt  <= wait_d;
      cpu_din   <= din_d;
      dtack_n   <= dtack_d;
      berr_n    <= berr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_sel   <= sel_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
    end
  end

  always_comb begin
    state_d = state;
    rw_d    = rw_q;
    abort_d = abort_q;
    wait_d  = wait_cnt;
    din_d   = cpu_din;
    dtack_d = dtack_n;
    berr_d  = berr_n;
    req_d   = mem_req;
    we_d    = mem_we;
    sel_d   = mem_sel;
    addr_d  = mem_addr;
    be_d    = mem_be;
    wdata_d = mem_wdata;
    strobe  = ~uds_n | ~lds_n;
    aborted = abort_q | as_n;
    region  = decode_region(addr);

    case (state)
      IDLE: begin
        if (!as_n && strobe) begin
          addr_d  = addr;
          be_d    = {~uds_n, ~lds_n};
          rw_d    = rw;
          wdata_d = cpu_dout;
          sel_d   = region;
          abort_d = 1'b0;
          if (!rw && (region == REG_ROM) && !C_ROM_WRITABLE) begin
            wait_d  = WAIT_INIT;
            state_d = WAIT;
          end else begin
            req_d   = 1'b1;
            we_d    = ~rw;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        abort_d = aborted;
        // An abandoned cycle still completes the memory handshake, then skips DTACK
        if (mem_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (aborted) begin
            state_d = IDLE;
          end else begin
            if (rw_q) begin
              din_d = mem_rdata;
            end
            wait_d  = WAIT_INIT;
            state_d = WAIT;
          end
        end else if (wd_count == WD_LAST) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (aborted) begin
            state_d = IDLE;
          end else begin
            berr_d  = 1'b0;
            state_d = BERR;
          end
        end
      end

      WAIT: begin
        if (as_n) begin
          state_d = IDLE;
        end else if (wait_cnt == 4'd0) begin
          dtack_d = 1'b0;
          state_d = HOLD;
        end else begin
          wait_d = wait_cnt - 4'd1;
        end
      end

      HOLD: begin
        if (as_n || (uds_n && lds_n)) begin
          dtack_d = 1'b1;
          state_d = IDLE;
        end
      end

      BERR: begin
        if (as_n) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Slave end of the fx68k asynchronous bus; replaces the tied-low DTACKn.
- Decodes each CPU cycle (ASn/UDSn/LDSn/eRWn/eab) into a single memory request with byte enables and waits for the memory's acknowledge.
- Returns read data, then drives DTACKn; a watchdog raises BERRn when the memory does not answer.
- Sits between fx68k and the ROM/VRAM/RAM (BRAM or SDRAM) back-ends, all in the clk_cpu domain.

Parameters:
- C_WAIT, 0, extra clk cycles inserted between mem_ack and DTACKn assertion (0..15).
- C_TIMEOUT_BITS, 8, width of watchdog counter; BERRn asserts when it saturates (2^n-1 cycles).
- C_ROM_WRITABLE, 0, 1: CPU writes to ROM region are forwarded; 0: acknowledged but dropped.

Ports:
- clk  in  1  clk_cpu, same clock that drives fx68k.
- reset  in  1  asynchronous, active-high.
- as_n  in  1  CPU address strobe.
- uds_n  in  1  upper data strobe.
- lds_n  in  1  lower data strobe.
- rw  in  1  1=read, 0=write.
- addr  in  23  CPU eab[23:1].
- cpu_dout  in  16  write data from CPU.
- cpu_din  out  16  registered read data to CPU iEdb.
- dtack_n  out  1  data acknowledge.
- berr_n  out  1  bus error.
- mem_req  out  1  request, held until mem_ack.
- mem_we  out  1  write qualifier, valid with mem_req.
- mem_sel  out  2  region: 0 ROM (addr[17:15]<2), 1 VRAM (==2), 2 RAM (>2).
- mem_addr  out  23  latched addr.
- mem_be  out  2  {~uds_n,~lds_n} latched.
- mem_wdata  out  16  latched cpu_dout.
- mem_rdata  in  16  read data, valid in mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- CPU inputs are synchronous to clk (fx68k is clk-driven); no synchronisers.
- Reset values: dtack_n=1, berr_n=1, mem_req=0, mem_we=0, cpu_din=0, mem_sel=0, mem_addr=0, mem_be=0, mem_wdata=0, state IDLE.
- IDLE: start when as_n=0 and (uds_n=0 or lds_n=0).
  - Latch addr, be, rw, cpu_dout, and region.
  - If write and region ROM and C_ROM_WRITABLE=0, go to WAIT with no request.
  - Otherwise assert mem_req next cycle and go to REQ.
- REQ: mem_req=1, mem_we=~rw_latched; watchdog counts each cycle.
  - On mem_ack: drop mem_req the same edge, capture mem_rdata into cpu_din if read, load wait counter with C_WAIT, go to WAIT.
  - On watchdog saturation (ack not yet seen): drop mem_req, berr_n=0, go to BERR.
  - mem_ack in the saturation cycle wins over the error.
- WAIT: decrement wait counter; at 0, dtack_n=0 and go to HOLD.
  - C_WAIT=0 gives dtack_n low 1 cycle after mem_ack, i.e. 2 cycles after the mem_req rise for a zero-latency memory.
- HOLD: dtack_n=0 and cpu_din stable until both uds_n=1 and lds_n=1 (or as_n=1).
  - Then dtack_n=1 and return to IDLE.
  - Read-modify-write (TAS) keeps as_n low while the strobes drop and reassert; this yields a second independent transaction.
- BERR: berr_n=0 until as_n=1, then berr_n=1 and go to IDLE.
- as_n rising in REQ (aborted cycle): keep mem_req until mem_ack, discard the data, skip DTACK, return to IDLE. The memory handshake is never broken.
- Byte reads: cpu_din returns the full word and the CPU selects the lane. Byte writes: mem_be reflects only the active strobe.
- Watchdog clears on each IDLE exit and does not wrap (saturating).
- Reset mid-cycle returns to IDLE immediately with all outputs at reset values. Memories must tolerate a dropped mem_req.

Decomposition:
- Shared package m68k_bus_pkg: state encoding (IDLE, REQ, WAIT, HOLD, BERR), region constants REG_ROM=0, REG_VRAM=1, REG_RAM=2, and the decode function of addr[17:15].
- No sub-module is needed. The watchdog counter may be a small generic saturating counter module, sat_counter.

Test Plan:
- Word read at addr 0x000100 (ROM), mem_ack 3 cycles after req with rdata 0x4E71, C_WAIT=0 -> mem_sel=0, mem_be=2'b11, cpu_din=0x4E71, dtack_n low 1 cycle after ack until strobes release.
- Byte write LDS only to 0x018002 (RAM) with cpu_dout 0x00AB -> mem_sel=2, mem_we=1, mem_be=2'b01, mem_wdata=0x00AB, single mem_req pulse train ending at ack.
- Write to ROM with C_ROM_WRITABLE=0 -> mem_req never asserted, dtack_n low 1 cycle after strobe.
- No mem_ack, C_TIMEOUT_BITS=4 -> berr_n low 15 cycles after mem_req, released when as_n rises, dtack_n stays 1.
- C_WAIT=3, VRAM read at 0x010000 -> mem_sel=1, dtack_n low exactly 4 cycles after ack.
- TAS: as_n held low, strobes pulse twice (read then write) -> two mem_req transactions, two dtack_n assertions. Async reset asserted during REQ -> all outputs at reset values in the same cycle.
